// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
// Shared frame-buffer types and default geometry (480x360 pages of 8-bit encoded colour).
package fb_pkg;
    localparam int FB_DEPTH = 172800;
    localparam int ADDR_W   = 18;

    typedef logic [7:0] color_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        CLEAR = 2'd2,
        ACK   = 2'd3
    } page_state_t;
endpackage

// File: rtl/fb_page_sequencer.sv
`timescale 1ns/1ps
// Page-swap FSM: waits for a frame boundary to flip front_page, optionally clears the new back page, then pulses swap_ack.
// Clear writes are issued combinationally (clr_vld) and stall in any cycle the display owns the memory.
module fb_page_sequencer #(
    parameter int ADDR_W   = fb_pkg::ADDR_W,
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                swap_req,
    input  logic                frame_start,
    input  logic                disp_req,
    output fb_pkg::page_state_t state,
    output logic                front_page,
    output logic                clr_vld,
    output logic [ADDR_W-1:0]   clr_addr,
    output logic                swap_ack
);
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);

    page_state_t       state_nxt;
    logic              front_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= RUN;
            front_page <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            front_page <= front_nxt;
            clr_cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        front_nxt = front_page;
        cnt_nxt   = clr_cnt;
        case (state)
            RUN: begin
                if (swap_req) state_nxt = PEND;
            end
            PEND: begin
                if (frame_start) begin
                    front_nxt = ~front_page;
                    state_nxt = CLEAR_EN ? CLEAR : ACK;
                end
            end
            CLEAR: begin
                // Display has priority; the clear simply waits out its cycles.
                if (!disp_req) begin
                    if (clr_cnt == CLR_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ACK;
                    end else begin
                        cnt_nxt = clr_cnt + 1'b1;
                    end
                end
            end
            ACK: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign clr_vld  = (state == CLEAR) & ~disp_req;
    assign clr_addr = clr_cnt;
    assign swap_ack = (state == ACK);
endmodule

// File: rtl/fb_arbiter.sv
`timescale 1ns/1ps
// Single-port frame-buffer arbiter with double buffering; one access per cycle, display > clear > draw, 2-cycle pipelined reads.
// Draw writes are backpressured (wr_ready low) whenever the display reads or a page swap/clear is in progress.
module fb_arbiter #(
    parameter int             FB_DEPTH    = fb_pkg::FB_DEPTH,
    parameter int             ADDR_W      = fb_pkg::ADDR_W,
    parameter bit             CLEAR_EN    = 1'b1,
    parameter fb_pkg::color_t CLEAR_COLOR = 8'h00
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    input  logic              frame_start,
    output logic              front_page,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    import fb_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(FB_DEPTH);

    page_state_t       state;
    logic              clr_vld;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_p1;
    logic              wr_fire;
    logic              wr_in_range;

    fb_page_sequencer #(
        .ADDR_W   (ADDR_W),
        .FB_DEPTH (FB_DEPTH),
        .CLEAR_EN (CLEAR_EN)
    ) u_seq (
        .Clk         (Clk),
        .Reset       (Reset),
        .swap_req    (swap_req),
        .frame_start (frame_start),
        .disp_req    (disp_req),
        .state       (state),
        .front_page  (front_page),
        .clr_vld     (clr_vld),
        .clr_addr    (clr_addr),
        .swap_ack    (swap_ack)
    );

    // Out-of-range writes still handshake so the drawer never stalls on them.
    assign wr_ready    = Reset & (state == RUN) & ~disp_req;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
    assign disp_data   = disp_valid ? mem_rdata : 8'h00;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'h00;
            rd_p1      <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            rd_p1      <= disp_req;
            disp_valid <= rd_p1;
            mem_we     <= 1'b0;
            if (disp_req) begin
                mem_addr <= {front_page, disp_addr};
            end else if (clr_vld) begin
                mem_addr  <= {~front_page, clr_addr};
                mem_we    <= 1'b1;
                mem_wdata <= CLEAR_COLOR;
            end else if (wr_fire && wr_in_range) begin
                mem_addr  <= {~front_page, wr_addr};
                mem_we    <= 1'b1;
                mem_wdata <= wr_data;
            end
        end
    end
endmodule
